// File: rtl/ff_stim_checker.sv
// Self-checking stimulus/response harness for a registered flip-flop DUT: LFSR stimulus out,
// latency-aligned compare of the response. Optional macro FF_STOP_ON_ERR_EN ends a run at the first mismatch.
module ff_stim_checker #(
  parameter int          SIZE     = 1,
  parameter int          LATENCY  = 1,
  parameter int          NUM_VECS = 16,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [SIZE-1:0] data_i,
  input  logic [SIZE-1:0] data_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     err_count,
  output logic [15:0]     vec_count,
  output logic [15:0]     fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECS - 1);

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [SIZE-1:0] data_i_q, data_i_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]     err_q, err_d, vec_q, vec_d, fail_q, fail_d;
  logic [LATENCY:0] vld_q, vld_d;
  logic [SIZE-1:0] dat_q [0:LATENCY];
  logic [SIZE-1:0] dat_d [0:LATENCY];
  logic [15:0]     idx_q [0:LATENCY];
  logic [15:0]     idx_d [0:LATENCY];

  logic            older_busy, mismatch, first_err, stop, new_run, launch;
  logic [15:0]     launch_idx, lfsr_src;

  // Next-state, stimulus launch, expected-value pipe and compare logic.
  always_comb begin
    older_busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      older_busy = older_busy | vld_q[k];
    end
    mismatch  = vld_q[LATENCY] && (data_o != dat_q[LATENCY]);
    first_err = mismatch && (err_q == 16'h0000);
`ifdef FF_STOP_ON_ERR_EN
    stop = first_err;
`else
    stop = 1'b0;
`endif
    new_run    = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    launch     = new_run || ((state_q == S_RUN) && !stop);
    launch_idx = new_run ? 16'h0000 : vec_q;
    lfsr_src   = new_run ? SEED_EFF : lfsr_q;

    vld_d[0] = launch;
    dat_d[0] = launch ? lfsr_src[SIZE-1:0] : {SIZE{1'b0}};
    idx_d[0] = launch ? launch_idx : 16'h0000;
    for (int k = 1; k <= LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      dat_d[k] = dat_q[k-1];
      idx_d[k] = idx_q[k-1];
    end
    if (stop) begin
      vld_d = {(LATENCY+1){1'b0}};
    end else begin
      vld_d = vld_d;
    end

    if (new_run) begin
      err_d  = 16'h0000;
      fail_d = 16'hFFFF;
    end else if (mismatch) begin
      err_d  = (err_q != 16'hFFFF) ? err_q + 16'h0001 : err_q;
      fail_d = first_err ? idx_q[LATENCY] : fail_q;
    end else begin
      err_d  = err_q;
      fail_d = fail_q;
    end

    if (launch) begin
      data_i_d = lfsr_src[SIZE-1:0];
      lfsr_d   = lfsr_step(lfsr_src);
      vec_d    = launch_idx + 16'h0001;
    end else begin
      data_i_d = {SIZE{1'b0}};
      lfsr_d   = lfsr_q;
      vec_d    = vec_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (new_run) begin
          state_d = (LAST_IDX == 16'h0000) ? S_DRAIN : S_RUN;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (launch_idx == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // Only stage LATENCY may still be live: it is compared on this edge.
        if (stop || !older_busy) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == 16'h0000);
  end

  // State, counters, pipe and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_EFF;
      data_i_q <= {SIZE{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 16'h0000;
      vec_q    <= 16'h0000;
      fail_q   <= 16'hFFFF;
      vld_q    <= {(LATENCY+1){1'b0}};
      for (int k = 0; k <= LATENCY; k++) begin
        dat_q[k] <= {SIZE{1'b0}};
        idx_q[k] <= 16'h0000;
      end
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      data_i_q <= data_i_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      vec_q    <= vec_d;
      fail_q   <= fail_d;
      vld_q    <= vld_d;
      for (int k = 0; k <= LATENCY; k++) begin
        dat_q[k] <= dat_d[k];
        idx_q[k] <= idx_d[k];
      end
    end
  end

  assign data_i    = data_i_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_count = vec_q;
  assign fail_idx  = fail_q;

endmodule
